if_id_skid: RTL

IF_ID_SKID -- requirements
Module: if_id_skid

---
 rtl/if_id_pkg.sv | 15 +
 rtl/sat_counter.sv | 24 ++
 rtl/if_id_skid.sv | 132 +++++++++++++
 3 files changed

// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared types and widths for the IF/ID skid stage
// Contents: skid state encoding, default payload widths, counter width.
package if_id_pkg;

   localparam int PC_BITS_DEFAULT    = 32;
   localparam int INSTR_BITS_DEFAULT = 32;
   localparam int CNT_BITS           = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-low reset, clears count
//   en    in   count one per enabled cycle
//   count out  current value, sticks at all-ones
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - two-entry (main + skid) IF/ID pipeline register
// Optional feature: define IF_ID_PERF_EN to add stall/flush counters.
// Ports:
//   clk                 in   rising-edge clock
//   rst                 in   synchronous active-low reset
//   i_valid/o_ready     upstream handshake, o_ready is registered
//   i_PCNext, i_instruction   upstream payload
//   i_flush             in   drop every held entry and any same-cycle input
//   o_valid/i_ready     downstream handshake
//   o_PCNext, o_instruction   downstream payload (0 / NOP_INSTR when idle)
//   o_stall_cnt, o_flush_cnt  perf counters (IF_ID_PERF_EN only)
module if_id_skid
   import if_id_pkg::*;
#(
   parameter int                          PC_BITS          = PC_BITS_DEFAULT,
   parameter int                          INSTRUCTION_BITS = INSTR_BITS_DEFAULT,
   parameter logic [INSTRUCTION_BITS-1:0] NOP_INSTR        = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [PC_BITS-1:0]          i_PCNext,
   input  logic [INSTRUCTION_BITS-1:0] i_instruction,
   input  logic                        i_flush,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [PC_BITS-1:0]          o_PCNext,
   output logic [INSTRUCTION_BITS-1:0] o_instruction
`ifdef IF_ID_PERF_EN
   ,
   output logic [CNT_BITS-1:0]         o_stall_cnt,
   output logic [CNT_BITS-1:0]         o_flush_cnt
`endif
);

   skid_state_t                 state;
   logic [PC_BITS-1:0]          main_pc;
   logic [INSTRUCTION_BITS-1:0] main_instr;
   logic [PC_BITS-1:0]          skid_pc;
   logic [INSTRUCTION_BITS-1:0] skid_instr;
   logic                        valid_q;
   logic                        ready_q;
   logic                        in_fire;
   logic                        out_fire;

   assign in_fire  = i_valid & ready_q;
   assign out_fire = valid_q & i_ready;

   // main is forced to 0/NOP whenever the stage is empty, so the payload
   // outputs come straight from flops with no idle mux.
   assign o_valid       = valid_q;
   assign o_ready       = ready_q;
   assign o_PCNext      = main_pc;
   assign o_instruction = main_instr;

   always_ff @(posedge clk) begin
      if (!rst || i_flush) begin
         state      <= ST_EMPTY;
         main_pc    <= '0;
         main_instr <= NOP_INSTR;
         skid_pc    <= '0;
         skid_instr <= NOP_INSTR;
         valid_q    <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_pc    <= i_PCNext;
                  main_instr <= i_instruction;
                  valid_q    <= 1'b1;
                  state      <= ST_HALF;
               end
            end
            ST_HALF: begin
               if (in_fire && out_fire) begin
                  main_pc    <= i_PCNext;
                  main_instr <= i_instruction;
               end else if (in_fire) begin
                  // downstream stalled: park the new entry behind main
                  skid_pc    <= i_PCNext;
                  skid_instr <= i_instruction;
                  ready_q    <= 1'b0;
                  state      <= ST_FULL;
               end else if (out_fire) begin
                  main_pc    <= '0;
                  main_instr <= NOP_INSTR;
                  valid_q    <= 1'b0;
                  state      <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_pc    <= skid_pc;
                  main_instr <= skid_instr;
                  skid_pc    <= '0;
                  skid_instr <= NOP_INSTR;
                  ready_q    <= 1'b1;
                  state      <= ST_HALF;
               end
            end
            default: begin
               main_pc    <= '0;
               main_instr <= NOP_INSTR;
               valid_q    <= 1'b0;
               ready_q    <= 1'b1;
               state      <= ST_EMPTY;
            end
         endcase
      end
   end

`ifdef IF_ID_PERF_EN
   sat_counter #(.WIDTH(CNT_BITS)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (valid_q & ~i_ready),
      .count (o_stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_BITS)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (i_flush),
      .count (o_flush_cnt)
   );
`else
   // no performance counters in this build
`endif

endmodule
